// File: rtl/recovery_rx_framer_if.sv
// Byte-stream, payload, PEC-engine and status signals of recovery_rx_framer.
// slave: the framer side; master: the surrounding target/PEC/CSR logic.
interface recovery_rx_framer_if;
   logic [6:0]  addr_i;
   logic        rx_start_i;
   logic        rx_stop_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic [7:0]  cmd_o;
   logic [15:0] len_o;
   logic        data_valid_o;
   logic [7:0]  data_o;
   logic        data_last_o;
   logic        data_ready_i;
   logic        pec_rst_no;
   logic        pec_valid_o;
   logic [7:0]  pec_dat_o;
   logic [7:0]  crc_i;
   logic        frame_done_o;
   logic        frame_ok_o;
   logic        err_pec_o;
   logic        err_len_o;

   modport slave (
      input  addr_i, rx_start_i, rx_stop_i, rx_valid_i, rx_data_i, data_ready_i, crc_i,
      output rx_ready_o, cmd_o, len_o, data_valid_o, data_o, data_last_o,
             pec_rst_no, pec_valid_o, pec_dat_o,
             frame_done_o, frame_ok_o, err_pec_o, err_len_o
   );

   modport master (
      output addr_i, rx_start_i, rx_stop_i, rx_valid_i, rx_data_i, data_ready_i, crc_i,
      input  rx_ready_o, cmd_o, len_o, data_valid_o, data_o, data_last_o,
             pec_rst_no, pec_valid_o, pec_dat_o,
             frame_done_o, frame_ok_o, err_pec_o, err_len_o
   );
endinterface

// File: rtl/recovery_rx_framer.sv
// SMBus/I3C recovery write-frame parser (CMD, LEN_L, LEN_H, payload, PEC) feeding an external CRC-8 PEC engine.
// Build option RECOVERY_RX_PEC_CHECK_EN: when defined, a non-zero PEC residue at stop raises err_pec_o.
module recovery_rx_framer #(
   parameter int unsigned MAX_LEN = 255
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   recovery_rx_framer_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_ADDR, S_CMD, S_LENL, S_LENH, S_DATA, S_PEC, S_WSTOP, S_DRAIN
   } state_t;

   localparam logic [15:0] MaxLen = 16'(MAX_LEN);

   state_t      state_q, state_d;
   logic [7:0]  cmd_q, len_lo_q;
   logic [15:0] len_q, cnt_q, len_rx;
   logic        done_q, ok_q, err_pec_q, err_len_q;
   logic        rx_ready, accept, pec_bad;
   logic        pec_rst_n, pec_valid, data_valid;
   logic [7:0]  pec_dat;
   logic        end_frame, end_len, end_pec;

   assign len_rx = {bus.rx_data_i, len_lo_q};
   assign accept = bus.rx_valid_i && rx_ready;

`ifdef RECOVERY_RX_PEC_CHECK_EN
   assign pec_bad = (bus.crc_i != 8'h00);
`else
   logic unused_crc;
   assign unused_crc = ^bus.crc_i;
   assign pec_bad    = 1'b0;
`endif

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves it unassigned (no latch).
      state_d   = state_q;
      end_frame = 1'b0;
      end_len   = 1'b0;
      end_pec   = 1'b0;
      if (bus.rx_start_i) begin
         // Repeated start cuts the frame short, except in WSTOP where the frame is complete.
         state_d = S_CLR;
         if (state_q == S_WSTOP) begin
            end_frame = 1'b1;
            end_pec   = pec_bad;
         end else if (state_q != S_IDLE) begin
            end_frame = 1'b1;
            end_len   = 1'b1;
         end
      end else begin
         case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_WSTOP: begin
               if (bus.rx_stop_i) begin
                  state_d   = S_IDLE;
                  end_frame = 1'b1;
                  end_pec   = pec_bad;
               end else if (accept) begin
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Only a length error ever leads here, so the latched error is implied by the state.
               if (bus.rx_stop_i) begin
                  state_d   = S_IDLE;
                  end_frame = 1'b1;
                  end_len   = 1'b1;
               end
            end
            default: begin
               if (bus.rx_stop_i) begin
                  state_d   = S_IDLE;
                  end_frame = 1'b1;
                  end_len   = 1'b1;
               end else begin
                  case (state_q)
                     S_CLR:  state_d = S_ADDR;
                     S_ADDR: state_d = S_CMD;
                     S_CMD:  if (accept) state_d = S_LENL;
                     S_LENL: if (accept) state_d = S_LENH;
                     S_LENH: begin
                        if (accept) begin
                           if (len_rx > MaxLen)      state_d = S_DRAIN;
                           else if (len_rx == 16'd0) state_d = S_PEC;
                           else                      state_d = S_DATA;
                        end
                     end
                     S_DATA: if (accept && cnt_q == 16'd1) state_d = S_PEC;
                     S_PEC:  if (accept) state_d = S_WSTOP;
                     default: state_d = state_q;
                  endcase
               end
            end
         endcase
      end
   end

   always_comb begin
      rx_ready   = 1'b0;
      pec_rst_n  = 1'b1;
      pec_valid  = 1'b0;
      pec_dat    = bus.rx_data_i;
      data_valid = 1'b0;
      case (state_q)
         S_CLR:  pec_rst_n = 1'b0;
         S_ADDR: begin
            pec_valid = 1'b1;
            pec_dat   = {bus.addr_i, 1'b0};
         end
         S_CMD, S_LENL, S_LENH, S_PEC: begin
            rx_ready  = !bus.rx_start_i;
            pec_valid = bus.rx_valid_i && !bus.rx_start_i;
         end
         S_WSTOP, S_DRAIN: rx_ready = !bus.rx_start_i;
         S_DATA: begin
            rx_ready   = bus.data_ready_i && !bus.rx_start_i;
            data_valid = bus.rx_valid_i && !bus.rx_start_i;
            pec_valid  = bus.rx_valid_i && bus.data_ready_i && !bus.rx_start_i;
         end
         default: rx_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_q     <= 8'h00;
         len_lo_q  <= 8'h00;
         len_q     <= 16'h0000;
         cnt_q     <= 16'h0000;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         err_pec_q <= 1'b0;
         err_len_q <= 1'b0;
      end else begin
         done_q    <= end_frame;
         ok_q      <= end_frame && !end_len && !end_pec;
         err_pec_q <= end_pec;
         err_len_q <= end_len;
         if (accept) begin
            case (state_q)
               S_CMD:  cmd_q    <= bus.rx_data_i;
               S_LENL: len_lo_q <= bus.rx_data_i;
               S_LENH: begin
                  len_q <= len_rx;
                  cnt_q <= len_rx;
               end
               S_DATA: cnt_q <= cnt_q - 16'd1;
               default: cnt_q <= cnt_q;
            endcase
         end
      end
   end

   assign bus.rx_ready_o   = rx_ready;
   assign bus.cmd_o        = cmd_q;
   assign bus.len_o        = len_q;
   assign bus.data_valid_o = data_valid;
   assign bus.data_o       = bus.rx_data_i;
   assign bus.data_last_o  = (state_q == S_DATA) && (cnt_q == 16'd1);
   assign bus.pec_rst_no   = pec_rst_n;
   assign bus.pec_valid_o  = pec_valid;
   assign bus.pec_dat_o    = pec_dat;
   assign bus.frame_done_o = done_q;
   assign bus.frame_ok_o   = ok_q;
   assign bus.err_pec_o    = err_pec_q;
   assign bus.err_len_o    = err_len_q;

endmodule

// File: tb/tb_recovery_rx_framer.sv
// Self-checking bench for recovery_rx_framer: CRC-8 PEC engine model, directed frames and random frames.
// Expectations follow RECOVERY_RX_PEC_CHECK_EN when it is defined for the build.
module tb_recovery_rx_framer;

   localparam int MAX_LEN = 255;
`ifdef RECOVERY_RX_PEC_CHECK_EN
   localparam bit PEC_CHECK = 1'b1;
`else
   localparam bit PEC_CHECK = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];

   logic clk_i;
   logic rst_ni;
   recovery_rx_framer_if bus ();

   recovery_rx_framer #(.MAX_LEN(MAX_LEN)) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   int         n_total   = 0;
   int         n_bad     = 0;
   int         n_done    = 0;
   int         n_pec_rst = 0;
   int         n_starts  = 0;
   bit         pec_rst_prev = 1'b0;
   logic [8:0] got_q[$];
   logic [7:0] crc_q;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [7:0] crc_step(input logic [7:0] c_in, input logic [7:0] d);
      logic [7:0] c;
      c = c_in ^ d;
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction

   function automatic logic [7:0] crc8(input bq_t b);
      logic [7:0] c;
      c = 8'h00;
      foreach (b[i]) c = crc_step(c, b[i]);
      return c;
   endfunction

   function automatic bq_t seq(input int n, input logic [7:0] base);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
      return q;
   endfunction

   // PEC engine stand-in: synchronous reset from pec_rst_no ANDed with the system reset.
   always @(posedge clk_i) begin
      if (!(rst_ni && bus.pec_rst_no)) crc_q <= 8'h00;
      else if (bus.pec_valid_o)         crc_q <= crc_step(crc_q, bus.pec_dat_o);
   end
   assign bus.crc_i = crc_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk_i);
         if (bus.data_valid_o && bus.data_ready_i) got_q.push_back({bus.data_last_o, bus.data_o});
         if (bus.frame_done_o) n_done++;
         else check("status_idle", 32'({bus.frame_ok_o, bus.err_pec_o, bus.err_len_o}), 32'd0);
         if (!bus.pec_rst_no) begin
            n_pec_rst++;
            check("pec_rst_single", 32'(pec_rst_prev), 32'd0);
         end
         pec_rst_prev = !bus.pec_rst_no;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // All tasks below start and end 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = b;
      forever begin
         @(negedge clk_i);
         if (bus.rx_ready_o) break;
         n++;
         if (n > 40) begin
            check("ready_wait", 32'(bus.rx_ready_o), 32'd1);
            break;
         end
      end
      @(posedge clk_i); #1;
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic stall(input int n, input logic [7:0] b);
      bus.data_ready_i = 1'b0;
      bus.rx_valid_i   = 1'b1;
      bus.rx_data_i    = b;
      repeat (n) begin
         @(negedge clk_i);
         check("stall_ready", 32'(bus.rx_ready_o), 32'd0);
      end
      @(posedge clk_i); #1;
      bus.data_ready_i = 1'b1;
   endtask

   task automatic pulse_start();
      bus.rx_start_i = 1'b1;
      n_starts++;
      @(posedge clk_i); #1;
      bus.rx_start_i = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.rx_stop_i = 1'b1;
      @(posedge clk_i); #1;
      bus.rx_stop_i = 1'b0;
   endtask

   task automatic frame(input string tag, input logic [6:0] addr, input logic [7:0] cmd,
                        input int len, input bq_t pay, input logic [7:0] pec_flip,
                        input int extra, input bit restart_end, input bit skip_start,
                        input bit rnd_stall, input int stall4_idx);
      bq_t        cov;
      logic [7:0] pec;
      int         done0, exp_beats;
      bit         drain, short_f, exp_len, exp_pec;
      got_q.delete();
      done0 = n_done;
      bus.addr_i = addr;
      if (!skip_start) pulse_start();
      cov.push_back({addr, 1'b0});
      cov.push_back(cmd);
      cov.push_back(8'(len));
      cov.push_back(8'(len >> 8));
      for (int i = 1; i < 4; i++) send_byte(cov[i]);
      drain   = len > MAX_LEN;
      short_f = !drain && (pay.size() < len);
      foreach (pay[i]) begin
         if (!drain && rnd_stall && $urandom_range(3) == 0) stall(int'($urandom_range(3, 1)), pay[i]);
         if (!drain && i == stall4_idx) stall(4, pay[i]);
         send_byte(pay[i]);
         cov.push_back(pay[i]);
      end
      if (!short_f && !restart_end) begin
         pec = crc8(cov) ^ pec_flip;
         send_byte(pec);
         for (int i = 0; i < extra; i++) send_byte(8'($urandom));
      end
      exp_len = drain || short_f || restart_end || (extra > 0);
      exp_pec = PEC_CHECK && !exp_len && (pec_flip != 8'h00);
      if (restart_end) pulse_start();
      else             pulse_stop();
      @(negedge clk_i);
      check({tag, ":done"},    32'(bus.frame_done_o), 32'd1);
      check({tag, ":ok"},      32'(bus.frame_ok_o),   32'(!exp_len && !exp_pec));
      check({tag, ":err_pec"}, 32'(bus.err_pec_o),    32'(exp_pec));
      check({tag, ":err_len"}, 32'(bus.err_len_o),    32'(exp_len));
      @(posedge clk_i); #1;
      check({tag, ":done_count"}, 32'(n_done - done0), 32'd1);
      exp_beats = drain ? 0 : pay.size();
      check({tag, ":beats"}, 32'(got_q.size()), 32'(exp_beats));
      foreach (got_q[i]) begin
         if (i < exp_beats) begin
            check($sformatf("%s:data%0d", tag, i), 32'(got_q[i][7:0]), 32'(pay[i]));
            check($sformatf("%s:last%0d", tag, i), 32'(got_q[i][8]),   32'(i == len - 1));
         end
      end
      check({tag, ":cmd"}, 32'(bus.cmd_o), 32'(cmd));
      check({tag, ":len"}, 32'(bus.len_o), 32'(16'(len)));
   endtask

   initial begin
      int done0;
      bus.addr_i       = 7'h00;
      bus.rx_start_i   = 1'b0;
      bus.rx_stop_i    = 1'b0;
      bus.rx_valid_i   = 1'b0;
      bus.rx_data_i    = 8'h00;
      bus.data_ready_i = 1'b1;
      rst_ni           = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_rx_ready",   32'(bus.rx_ready_o),   32'd0);
      check("rst_pec_rst_n",  32'(bus.pec_rst_no),   32'd1);
      check("rst_pec_valid",  32'(bus.pec_valid_o),  32'd0);
      check("rst_data_valid", 32'(bus.data_valid_o), 32'd0);
      check("rst_data_last",  32'(bus.data_last_o),  32'd0);
      check("rst_done",       32'(bus.frame_done_o), 32'd0);
      check("rst_cmd",        32'(bus.cmd_o),        32'd0);
      check("rst_len",        32'(bus.len_o),        32'd0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // A stop with no frame open produces nothing.
      done0 = n_done;
      pulse_stop();
      @(negedge clk_i);
      check("idle_stop_done", 32'(bus.frame_done_o), 32'd0);
      @(posedge clk_i); #1;
      check("idle_stop_count", 32'(n_done - done0), 32'd0);

      frame("good",    7'h21, 8'h26, 3, seq(3, 8'h01), 8'h00, 0, 1'b0, 1'b0, 1'b0, -1);
      frame("bad_pec", 7'h21, 8'h26, 3, seq(3, 8'h01), 8'h01, 0, 1'b0, 1'b0, 1'b0, -1);
      frame("len0",    7'h21, 8'h22, 0, seq(0, 8'h00), 8'h00, 0, 1'b0, 1'b0, 1'b0, -1);
      frame("short",   7'h21, 8'h26, 3, seq(2, 8'h01), 8'h00, 0, 1'b0, 1'b0, 1'b0, -1);
      frame("extra",   7'h21, 8'h26, 3, seq(3, 8'h01), 8'h00, 2, 1'b0, 1'b0, 1'b0, -1);
      frame("too_long", 7'h21, 8'h26, 16'h0100, seq(3, 8'hAA), 8'h00, 0, 1'b0, 1'b0, 1'b0, -1);
      frame("stall",   7'h35, 8'h26, 8, seq(8, 8'h40), 8'h00, 0, 1'b0, 1'b0, 1'b0, 3);
      frame("restart", 7'h21, 8'h26, 3, seq(2, 8'h01), 8'h00, 0, 1'b1, 1'b0, 1'b0, -1);
      frame("after_rs", 7'h21, 8'h27, 3, seq(3, 8'h11), 8'h00, 0, 1'b0, 1'b1, 1'b0, -1);

      // Asynchronous reset in the middle of a frame: straight to idle, no done pulse.
      done0 = n_done;
      bus.addr_i = 7'h10;
      pulse_start();
      send_byte(8'h33);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_rx_ready",  32'(bus.rx_ready_o), 32'd0);
      check("arst_pec_rst_n", 32'(bus.pec_rst_no), 32'd1);
      check("arst_cmd",       32'(bus.cmd_o),      32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      check("arst_no_done", 32'(n_done - done0), 32'd0);

      for (int f = 0; f < 24; f++) begin
         bq_t        p;
         int         l, n, ex, gap;
         logic [7:0] flip;
         l = int'($urandom_range(6));
         n = l;
         if (l > 0 && $urandom_range(5) == 0) n = l - 1;
         p = seq(0, 8'h00);
         for (int i = 0; i < n; i++) p.push_back(8'($urandom));
         flip = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         ex   = ($urandom_range(5) == 0) ? 1 : 0;
         frame($sformatf("rnd%0d", f), 7'($urandom), 8'($urandom), l, p, flip, ex,
               1'b0, 1'b0, 1'b1, -1);
         gap = int'($urandom_range(3));
         for (int g = 0; g < gap; g++) begin
            @(posedge clk_i); #1;
         end
      end

      @(posedge clk_i); #1;
      check("pec_rst_count", 32'(n_pec_rst), 32'(n_starts));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
